rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Encoder counterpart of the single-cycle datapath's instruction decoder: turns symbolic instruction requests into 32-bit RV32I machine words and writes them into instruction memory.
- Used as an on-chip program loader ahead of the core in test and bring-up builds.
- Covers exactly the instruction subset the core decodes: add, sub, and, or, slt, sltu, addi, xori, ori, slti, sltiu, lw, sw, beq, bne, blt, bge, lui, jal, jalr.

Parameters:
- DEPTH, 64, instruction memory capacity in 32-bit words.
- ADDR_W, 8, byte-address width of imem_addr; DEPTH*4 <= 2**ADDR_W is required.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  request valid
- op_ready  output  1  block can accept a request
- op_kind  input  5  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 addi, 7 xori, 8 ori, 9 slti, 10 sltiu, 11 lw, 12 sw, 13 beq, 14 bne, 15 blt, 16 bge, 17 lui, 18 jal, 19 jalr; codes 20-31 are illegal
- rd, rs1, rs2  input  5 each  register fields; ignored where the format has no such field
- imm  input  32  signed byte offset or immediate; for lui, the full 32-bit value
- clear  input  1  synchronous restart: pointer to 0, err/full/done cleared
- finish  input  1  end-of-program pulse
- imem_we  output  1  one-cycle write strobe
- imem_addr  output  ADDR_W  byte address of the word being written
- imem_wdata  output  32  encoded instruction
- count  output  ADDR_W  number of words written so far
- err  output  1  sticky: illegal op_kind or immediate out of range
- full  output  1  DEPTH words written
- done  output  1  finish has been processed

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous and active-low. During reset all outputs are 0 and the state is IDLE.
- FSM states and transitions:
  - IDLE: op_ready=1. On op_valid && op_ready, latch all op fields and go to ENC.
  - ENC: op_ready=0. Register the encoded word and check legality.
    - Illegal op or immediate goes to ERR.
    - Otherwise go to WR.
  - WR: imem_we=1, imem_addr=count*4, imem_wdata=word; count increments. Go to FULL if count reaches DEPTH, otherwise to IDLE.
  - ERR: err=1, op_ready=0; nothing is written. Leave only on clear.
  - FULL: full=1, op_ready=0. Leave only on clear.
  - DONE: done=1, op_ready=0. Leave only on clear.
- Timing: latency from accept (cycle N) to imem_we is cycle N+2. Maximum throughput is one instruction per 3 cycles.
- Opcodes: R=0x33, I-ALU=0x13, lw=0x03 (funct3 010), sw=0x23 (funct3 010), branch=0x63, lui=0x37, jal=0x6F, jalr=0x67 (funct3 000).
- R-type funct3/funct7:
  - add 000/0x00, sub 000/0x20
  - and 111, or 110, slt 010, sltu 011
- I-ALU funct3: addi 000, xori 100, ori 110, slti 010, sltiu 011.
- Branch funct3: beq 000, bne 001, blt 100, bge 101.
- Immediate range rules (anything outside sets err):
  - I, S, jalr: -2048..2047.
  - B: even, -4096..4094.
  - J: even, -1048576..1048574.
  - U: imm[11:0] must be 0.
- Event priority (highest first): clear > finish > op_valid.
  - clear in any state, including mid-ENC/WR: no write is issued that cycle; the FSM returns to IDLE.
  - finish is honoured only in IDLE. If it coincides with op_valid, the op is dropped and op_ready deasserts that cycle.
- Without the optional feature, finish goes directly to DONE.

Optional Feature:
- Macro: RV_ENC_NOP_PAD_EN.
- Defined: finish enters a PAD state that writes NOP 0x00000013 (addi x0,x0,0) at one word per cycle from count up to DEPTH-1, then enters DONE. count ends at DEPTH; full stays 0. clear aborts the padding. If already full, finish goes directly to DONE.
- Undefined: the PAD state does not exist and finish goes directly to DONE.

Test Plan:
- add rd=3,rs1=1,rs2=2 after reset -> imem_we at accept+2, addr 0, wdata 0x002081B3, count=1.
- addi rd=5,rs1=0,imm=-1, then sw rs1=1,rs2=2,imm=8 -> writes 0xFFF00293 @0 and 0x0020A423 @4.
- beq rs1=1,rs2=2,imm=8, then jal rd=1,imm=16 -> writes 0x00208463 and 0x010000EF.
- addi imm=2048, and separately op_kind=25 -> err=1, op_ready=0, no imem_we, count unchanged; clear -> err=0, op_ready=1.
- DEPTH=4: issue 5 ops -> 4 writes at addrs 0,4,8,12, full=1, 5th op never accepted.
- RV_ENC_NOP_PAD_EN, DEPTH=8: 3 ops then finish -> 0x00000013 written at 12,16,20,24,28, done=1, count=8; assert clear mid-pad -> remaining pad writes stop.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// RV32I program loader: encodes symbolic instruction requests into machine words and streams them into imem.
// Optional RV_ENC_NOP_PAD_EN: on finish, fill the rest of imem with NOPs before reporting done.
module rv_instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [4:0]        op_kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              clear,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] count,
  output logic              err,
  output logic              full,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC,
    S_WR,
    S_ERR,
    S_FULL,
`ifdef RV_ENC_NOP_PAD_EN
    S_PAD,
`endif
    S_DONE
  } state_t;

  typedef enum logic [4:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLTU,
    K_ADDI, K_XORI, K_ORI, K_SLTI, K_SLTIU,
    K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE,
    K_LUI, K_JAL, K_JALR
  } kind_t;

  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;

`ifdef RV_ENC_NOP_PAD_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [4:0]        kind_q, rd_q, rs1_q, rs2_q;
  logic [31:0]       imm_q, word_q;
  logic [ADDR_W-1:0] count_q;
  logic              accept, wr, pad_wr;

  fmt_t        fmt;
  logic [2:0]  f3;
  logic [6:0]  f7, opc;
  logic        legal, imm_ok, enc_ok;
  logic [31:0] enc_word;

  // Immediate must survive truncation to its field, i.e. the dropped upper bits are pure sign extension.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign fits13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  assign fits21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    fmt   = F_R;
    f3    = 3'b000;
    f7    = 7'h00;
    opc   = 7'h33;
    legal = 1'b1;
    case (kind_q)
      K_ADD:   ;
      K_SUB:   f7 = 7'h20;
      K_AND:   f3 = 3'b111;
      K_OR:    f3 = 3'b110;
      K_SLT:   f3 = 3'b010;
      K_SLTU:  f3 = 3'b011;
      K_ADDI:  begin fmt = F_I; opc = 7'h13; end
      K_XORI:  begin fmt = F_I; opc = 7'h13; f3 = 3'b100; end
      K_ORI:   begin fmt = F_I; opc = 7'h13; f3 = 3'b110; end
      K_SLTI:  begin fmt = F_I; opc = 7'h13; f3 = 3'b010; end
      K_SLTIU: begin fmt = F_I; opc = 7'h13; f3 = 3'b011; end
      K_LW:    begin fmt = F_I; opc = 7'h03; f3 = 3'b010; end
      K_SW:    begin fmt = F_S; opc = 7'h23; f3 = 3'b010; end
      K_BEQ:   begin fmt = F_B; opc = 7'h63; end
      K_BNE:   begin fmt = F_B; opc = 7'h63; f3 = 3'b001; end
      K_BLT:   begin fmt = F_B; opc = 7'h63; f3 = 3'b100; end
      K_BGE:   begin fmt = F_B; opc = 7'h63; f3 = 3'b101; end
      K_LUI:   begin fmt = F_U; opc = 7'h37; end
      K_JAL:   begin fmt = F_J; opc = 7'h6F; end
      K_JALR:  begin fmt = F_I; opc = 7'h67; end
      default: legal = 1'b0;
    endcase

    enc_word = 32'h0;
    imm_ok   = 1'b1;
    case (fmt)
      F_R: enc_word = {f7, rs2_q, rs1_q, f3, rd_q, opc};
      F_I: begin
        enc_word = {imm_q[11:0], rs1_q, f3, rd_q, opc};
        imm_ok   = fits12;
      end
      F_S: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc};
        imm_ok   = fits12;
      end
      F_B: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc};
        imm_ok   = fits13 & ~imm_q[0];
      end
      F_U: begin
        enc_word = {imm_q[31:12], rd_q, opc};
        imm_ok   = ~(|imm_q[11:0]);
      end
      F_J: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
        imm_ok   = fits21 & ~imm_q[0];
      end
      default: enc_word = 32'h0;
    endcase
    enc_ok = legal & imm_ok;
  end

  // Ready is withheld while a higher-priority event (clear/finish) is present, and held low in reset.
  assign op_ready = rst_n & (state_q == S_IDLE) & ~clear & ~finish;
  assign accept   = op_ready & op_valid;

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    pad_wr  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (finish) begin
`ifdef RV_ENC_NOP_PAD_EN
            state_d = (count_q > LAST) ? S_DONE : S_PAD;
`else
            state_d = S_DONE;
`endif
          end else if (op_valid) begin
            state_d = S_ENC;
          end
        end
        S_ENC: state_d = enc_ok ? S_WR : S_ERR;
        S_WR: begin
          wr      = 1'b1;
          state_d = (count_q == LAST) ? S_FULL : S_IDLE;
        end
`ifdef RV_ENC_NOP_PAD_EN
        S_PAD: begin
          wr      = 1'b1;
          pad_wr  = 1'b1;
          state_d = (count_q == LAST) ? S_DONE : S_PAD;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q <= op_kind;
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        imm_q  <= imm;
      end
      if (state_q == S_ENC) word_q <= enc_word;
      if (clear)   count_q <= '0;
      else if (wr) count_q <= count_q + ADDR_W'(1);
    end
  end

  assign imem_we    = wr;
  assign imem_addr  = wr ? {count_q[ADDR_W-3:0], 2'b00} : '0;
`ifdef RV_ENC_NOP_PAD_EN
  assign imem_wdata = !wr ? 32'h0 : (pad_wr ? NOP : word_q);
`else
  assign imem_wdata = (wr && !pad_wr) ? word_q : 32'h0;
`endif
  assign count = count_q;
  assign err   = (state_q == S_ERR);
  assign full  = (state_q == S_FULL);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: table of hand-encoded instructions plus sequences for
// reset, clear mid-flight, full (DEPTH=4 instance) and finish handling.
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, clear = 1'b0, finish = 1'b0, sel = 1'b0;
  logic [4:0]  op_kind = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        a_ready, a_we, a_err, a_full, a_done;
  logic [7:0]  a_addr, a_count;
  logic [31:0] a_wdata;
  logic        b_ready, b_we, b_err, b_full, b_done;
  logic [7:0]  b_addr, b_count;
  logic [31:0] b_wdata;

  int n_vec = 0;
  int n_mis = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.DEPTH(64), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid & ~sel), .op_ready(a_ready),
    .op_kind(op_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .clear(clear & ~sel), .finish(finish & ~sel),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .count(a_count),
    .err(a_err), .full(a_full), .done(a_done)
  );

  rv_instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid & sel), .op_ready(b_ready),
    .op_kind(op_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .clear(clear & sel), .finish(finish & sel),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .count(b_count),
    .err(b_err), .full(b_full), .done(b_done)
  );

  logic        ready, we, err, full, done;
  logic [7:0]  addr, count;
  logic [31:0] wdata;
  assign ready = sel ? b_ready : a_ready;
  assign we    = sel ? b_we    : a_we;
  assign err   = sel ? b_err   : a_err;
  assign full  = sel ? b_full  : a_full;
  assign done  = sel ? b_done  : a_done;
  assign addr  = sel ? b_addr  : a_addr;
  assign count = sel ? b_count : a_count;
  assign wdata = sel ? b_wdata : a_wdata;

  typedef struct {
    logic [4:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_count = 0;
    #1;
    check("clear_ready", ready, 1);
    check("clear_count", count, 0);
    check("clear_err", err, 0);
    check("clear_full", full, 0);
    check("clear_done", done, 0);
  endtask

  // One request: ready at accept, busy in ENC, write (or err) at accept+2.
  task automatic apply_op(input vec_t v);
    @(negedge clk);
    op_kind = v.kind; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    op_valid = 1'b1;
    #1 check("accept_ready", ready, 1);
    @(negedge clk);
    op_valid = 1'b0;
    check("enc_busy", ready, 0);
    check("enc_no_we", we, 0);
    @(negedge clk);
    if (v.bad) begin
      check("err_set", err, 1);
      check("err_no_we", we, 0);
      check("err_busy", ready, 0);
      check("err_count", count, 32'(exp_count));
      @(negedge clk);
      check("err_sticky", err, 1);
      do_clear();
    end else begin
      check("wr_we", we, 1);
      check("wr_addr", addr, 32'(exp_count * 4));
      check("wr_data", wdata, v.word);
      exp_count++;
      @(negedge clk);
      check("wr_count", count, 32'(exp_count));
      check("wr_we_drop", we, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd0,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h0020_81B3}; // add
    vecs[1]  = '{5'd25, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b1, 32'h0};          // illegal kind
    vecs[2]  = '{5'd6,  5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0293}; // addi -1
    vecs[3]  = '{5'd12, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0020_A423}; // sw
    vecs[4]  = '{5'd13, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0020_8463}; // beq
    vecs[5]  = '{5'd18, 5'd1, 5'd0, 5'd0, 32'h0000_0010, 1'b0, 32'h0100_00EF}; // jal
    vecs[6]  = '{5'd1,  5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h4031_00B3}; // sub
    vecs[7]  = '{5'd2,  5'd4, 5'd5, 5'd6, 32'h0000_0000, 1'b0, 32'h0062_F233}; // and
    vecs[8]  = '{5'd3,  5'd4, 5'd5, 5'd6, 32'h0000_0000, 1'b0, 32'h0062_E233}; // or
    vecs[9]  = '{5'd4,  5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h0031_20B3}; // slt
    vecs[10] = '{5'd5,  5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h0031_30B3}; // sltu
    vecs[11] = '{5'd7,  5'd1, 5'd2, 5'd0, 32'h0000_07FF, 1'b0, 32'h7FF1_4093}; // xori 2047
    vecs[12] = '{5'd8,  5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 1'b0, 32'h8001_6093}; // ori -2048
    vecs[13] = '{5'd9,  5'd1, 5'd2, 5'd0, 32'h0000_0005, 1'b0, 32'h0051_2093}; // slti
    vecs[14] = '{5'd10, 5'd1, 5'd2, 5'd0, 32'h0000_0005, 1'b0, 32'h0051_3093}; // sltiu
    vecs[15] = '{5'd11, 5'd1, 5'd2, 5'd0, 32'h0000_0004, 1'b0, 32'h0041_2083}; // lw
    vecs[16] = '{5'd14, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE20_9EE3}; // bne -4
    vecs[17] = '{5'd15, 5'd0, 5'd1, 5'd2, 32'h0000_0FFE, 1'b0, 32'h7E20_CFE3}; // blt 4094
    vecs[18] = '{5'd16, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 1'b0, 32'h8020_D063}; // bge -4096
    vecs[19] = '{5'd17, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7}; // lui
    vecs[20] = '{5'd19, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 1'b0, 32'hFF81_00E7}; // jalr -8
    vecs[21] = '{5'd18, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b0, 32'h8000_006F}; // jal min
    vecs[22] = '{5'd6,  5'd0, 5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h0};          // addi 2048
    vecs[23] = '{5'd13, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 1'b1, 32'h0};          // beq odd
    vecs[24] = '{5'd17, 5'd1, 5'd0, 5'd0, 32'h0000_0123, 1'b1, 32'h0};          // lui low bits
    vecs[25] = '{5'd18, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b1, 32'h0};          // jal too far
    vecs[26] = '{5'd12, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 1'b1, 32'h0};          // sw -2049
    vecs[27] = '{5'd31, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b1, 32'h0};          // illegal kind

    // Reset: every output low, including op_ready.
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready, 1);

    for (int i = 0; i < 28; i++) apply_op(vecs[i]);

    // clear while the word is in ENC: nothing gets written.
    @(negedge clk);
    op_kind = 5'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_enc_we", we, 0);
    check("clr_enc_ready", ready, 1);
    check("clr_enc_count", count, 0);
    exp_count = 0;

    // clear in the WR cycle suppresses the strobe.
    @(negedge clk);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    #1 check("clr_wr_we", we, 0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_wr_count", count, 0);
    check("clr_wr_ready", ready, 1);
    check("clr_wr_we_after", we, 0);

    // DEPTH=4 instance fills up after four writes and refuses a fifth.
    sel = 1'b1;
    exp_count = 0;
    for (int i = 2; i < 6; i++) apply_op(vecs[i]);
    check("full_set", full, 1);
    check("full_ready", ready, 0);
    @(negedge clk);
    op_kind = 5'd0; op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_no_we", we, 0);
      check("full_no_ready", ready, 0);
    end
    op_valid = 1'b0;
    check("full_count", count, 4);
    check("full_sticky", full, 1);
    do_clear();
    sel = 1'b0;

    // finish with a coincident op: the op is dropped.
    apply_op(vecs[0]);
    apply_op(vecs[2]);
    apply_op(vecs[3]);
    @(negedge clk);
    op_kind = 5'd0; finish = 1'b1; op_valid = 1'b1;
    #1 check("finish_ready", ready, 0);
    @(negedge clk);
    finish = 1'b0; op_valid = 1'b0;
`ifdef RV_ENC_NOP_PAD_EN
    for (int i = exp_count; i < 64; i++) begin
      check("pad_we", we, 1);
      check("pad_addr", addr, 32'(i * 4));
      check("pad_data", wdata, 32'h0000_0013);
      @(negedge clk);
    end
    check("pad_done", done, 1);
    check("pad_count", count, 64);
    check("pad_full", full, 0);
    check("pad_we_end", we, 0);
    do_clear();
    // clear partway through padding stops the remaining writes.
    apply_op(vecs[0]);
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("pad2_we0", we, 1);
    check("pad2_addr0", addr, 4);
    @(negedge clk);
    check("pad2_we1", we, 1);
    clear = 1'b1;
    #1 check("pad2_clr_we", we, 0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pad2_stopped", we, 0);
    end
    check("pad2_done", done, 0);
    check("pad2_count", count, 0);
`else
    check("finish_done", done, 1);
    check("finish_no_we", we, 0);
    check("finish_busy", ready, 0);
    check("finish_count", count, 3);
    @(negedge clk);
    check("done_sticky", done, 1);
    do_clear();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
